// File: rtl/chunk_adder_if.sv
// Handshake and data bundle between a chunk_adder and its requester.
// The requester drives operands and start; the adder returns status and result.
interface chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             Cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] outS;
    logic             Cout;
    logic             ovf;

    modport master (
        output start, inA, inB, Cin, sub,
        input  busy, done, outS, Cout, ovf
    );

    modport slave (
        input  start, inA, inB, Cin, sub,
        output busy, done, outS, Cout, ovf
    );
endinterface

// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// with a one-cycle done pulse once all WIDTH/CHUNK chunks are written.
module chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    chunk_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             cout_reg;
    logic             ovf_reg;

    logic             accept;
    logic             last;
    int               idx;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry_in;

    assign accept = bus.start && (state != BUSY);
    assign last   = (cnt == CW'(NCH - 1));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        idx          = int'(cnt) * CHUNK;
        a_chunk      = a_reg[idx +: CHUNK];
        b_chunk      = b_reg[idx +: CHUNK];
        chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        // Carry into the chunk MSB recovered from the MSB sum bit and its two operands.
        msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = BUSY;
            BUSY:    if (last)      next_state = DONE;
            DONE:    next_state = bus.start ? BUSY : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every datapath register is reset, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B once here and seed the carry.
            a_reg <= bus.inA;
            b_reg <= bus.inB ^ {WIDTH{bus.sub}};
            carry <= bus.sub | bus.Cin;
            cnt   <= '0;
        end else if (state == BUSY) begin
            sum_reg[idx +: CHUNK] <= chunk_sum[CHUNK-1:0];
            carry                 <= chunk_sum[CHUNK];
            cnt                   <= cnt + 1'b1;
            if (last) begin
                cout_reg <= chunk_sum[CHUNK];
                ovf_reg  <= msb_carry_in ^ chunk_sum[CHUNK];
            end
        end
    end

    assign bus.busy = (state == BUSY);
    assign bus.done = (state == DONE);
    assign bus.outS = sum_reg;
    assign bus.Cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_chunk_adder.sv
// Scoreboard bench for chunk_adder at CHUNK = 4, 16 and 1 (WIDTH = 16), with an
// arithmetic reference model, latency/handshake checks and mid-operation reset.
module tb_chunk_adder;
    localparam int W    = 16;
    localparam int NDUT = 3;
    localparam int NCH_T [NDUT] = '{4, 1, 16};

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             start_v [NDUT];
    logic [W-1:0]     a_v     [NDUT];
    logic [W-1:0]     b_v     [NDUT];
    logic             cin_v   [NDUT];
    logic             sub_v   [NDUT];
    logic [NDUT-1:0]  busy_v;
    logic [NDUT-1:0]  done_v;
    logic [NDUT-1:0]  cout_v;
    logic [NDUT-1:0]  ovf_v;
    logic [NDUT-1:0][W-1:0] outs_v;

    exp_t exp_q  [NDUT][$];
    exp_t last_r [NDUT];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain W+1-bit addition of A and the effective B operand.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         m;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
        m.s  = full[W-1:0];
        m.c  = full[W];
        m.v  = (a[W-1] == bb[W-1]) && (m.s[W-1] != a[W-1]);
        return m;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CH = W / NCH_T[g];

        chunk_adder_if #(.WIDTH(W)) bus ();

        assign bus.start = start_v[g];
        assign bus.inA   = a_v[g];
        assign bus.inB   = b_v[g];
        assign bus.Cin   = cin_v[g];
        assign bus.sub   = sub_v[g];
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign outs_v[g] = bus.outS;
        assign cout_v[g] = bus.Cout;
        assign ovf_v[g]  = bus.ovf;

        chunk_adder #(.WIDTH(W), .CHUNK(CH)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        always @(negedge clk) begin : mon
            exp_t e;
            if (rst) begin
                exp_q[g].delete();
                last_r[g] = '{s: '0, c: 1'b0, v: 1'b0};
            end else if (bus.done) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("spurious_done%0d", g), 32'(bus.done), 32'd0);
                end else begin
                    e = exp_q[g].pop_front();
                    check($sformatf("outS%0d", g), 32'(bus.outS), 32'(e.s));
                    check($sformatf("Cout%0d", g), 32'(bus.Cout), 32'(e.c));
                    check($sformatf("ovf%0d", g),  32'(bus.ovf),  32'(e.v));
                    last_r[g] = e;
                end
            end
        end
    end

    task automatic launch(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input exp_t e);
        a_v[d]     = a;
        b_v[d]     = b;
        cin_v[d]   = cin;
        sub_v[d]   = sub;
        start_v[d] = 1'b1;
        exp_q[d].push_back(e);
    endtask

    task automatic wait_result(input int d, input bit glitch, output int busy_n, output int done_k);
        busy_n = 0;
        done_k = -1;
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (glitch && k == 2) begin
                start_v[d] = 1'b1;
                a_v[d]     = W'($urandom);
                b_v[d]     = W'($urandom);
                cin_v[d]   = 1'($urandom);
                sub_v[d]   = 1'($urandom);
            end else begin
                start_v[d] = 1'b0;
            end
            if (busy_v[d]) busy_n++;
            if (done_v[d]) begin
                done_k = k;
                check($sformatf("busy_done_excl%0d", d), 32'(busy_v[d]), 32'd0);
                break;
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
    endtask

    task automatic check_timing(input int d, input int bn, input int dk);
        check($sformatf("busy_cycles%0d", d), 32'(bn), 32'(NCH_T[d]));
        check($sformatf("done_cycle%0d", d),  32'(dk), 32'(NCH_T[d] + 1));
    endtask

    task automatic do_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input exp_t e, input bit glitch);
        int bn, dk;
        @(negedge clk);
        check($sformatf("hold%0d", d), 32'({outs_v[d], cout_v[d], ovf_v[d]}),
              32'({last_r[d].s, last_r[d].c, last_r[d].v}));
        launch(d, a, b, cin, sub, e);
        wait_result(d, glitch, bn, dk);
        check_timing(d, bn, dk);
    endtask

    task automatic abort_op(input int d);
        logic [W-1:0] a, b;
        int           seen;
        a = W'($urandom);
        b = W'($urandom);
        @(negedge clk);
        launch(d, a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
        @(negedge clk);
        start_v[d] = 1'b0;
        if (NCH_T[d] >= 2) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int dd = 0; dd < NDUT; dd++)
            check($sformatf("abort_zero%0d", dd),
                  32'({busy_v[dd], done_v[dd], outs_v[dd], cout_v[dd], ovf_v[dd]}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < NCH_T[d] + 3; k++) begin
            @(negedge clk);
            if (done_v[d]) seen++;
        end
        check($sformatf("no_done_after_abort%0d", d), 32'(seen), 32'd0);
        do_op(d, a, b, 1'b1, 1'b0, model(a, b, 1'b1, 1'b0), 1'b0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        int           bn, dk;
        logic [W-1:0] a, b;
        logic         cin, sub;

        for (int d = 0; d < NDUT; d++) begin
            start_v[d] = 1'b0;
            a_v[d]     = '0;
            b_v[d]     = '0;
            cin_v[d]   = 1'b0;
            sub_v[d]   = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("reset_state%0d", d),
                  32'({busy_v[d], done_v[d], outs_v[d], cout_v[d], ovf_v[d]}), 32'd0);

        // First start lands on the very first edge with rst low.
        rst = 1'b0;
        launch(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b0});
        wait_result(0, 1'b0, bn, dk);
        check_timing(0, bn, dk);

        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, c: 1'b0, v: 1'b1}, 1'b0);
        do_op(0, 16'h1234, 16'h4321, 1'b1, 1'b0, '{s: 16'h5556, c: 1'b0, v: 1'b0}, 1'b0);
        do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, '{s: 16'hFFFE, c: 1'b0, v: 1'b0}, 1'b0);
        do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, c: 1'b1, v: 1'b1}, 1'b0);

        // Start pulsed mid-operation with other operands must be ignored.
        do_op(0, 16'h0F0F, 16'h1111, 1'b0, 1'b0, '{s: 16'h2020, c: 1'b0, v: 1'b0}, 1'b1);

        // Back-to-back: start held during DONE, second done five cycles later.
        do_op(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b0}, 1'b0);
        launch(0, 16'h0003, 16'h0004, 1'b0, 1'b1, '{s: 16'hFFFF, c: 1'b0, v: 1'b0});
        wait_result(0, 1'b0, bn, dk);
        check_timing(0, bn, dk);

        for (int d = 0; d < NDUT; d++) abort_op(d);

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                a   = pick_operand();
                b   = pick_operand();
                cin = 1'($urandom);
                sub = 1'($urandom);
                do_op(d, a, b, cin, sub, model(a, b, cin, sub), 1'b0);
                if ($urandom_range(0, 3) == 0) begin
                    a   = pick_operand();
                    b   = pick_operand();
                    cin = 1'($urandom);
                    sub = 1'($urandom);
                    launch(d, a, b, cin, sub, model(a, b, cin, sub));
                    wait_result(d, 1'b0, bn, dk);
                    check_timing(d, bn, dk);
                end
            end
        end

        repeat (5) @(negedge clk);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("queue_empty%0d", d), 32'(exp_q[d].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
